// File: rtl/rv_pkg.sv
// Shared write-back types and constants for the register-file write-port slice.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // True when a live entry targets register idx.
  function automatic logic rd_match(input logic v, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] idx);
    return v && (rd == idx);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a write-back producer (valid/ready handshake).
module wb_slot
  import rv_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  logic    valid_i,
  input  wb_req_t req_i,
  input  logic    grant_i,
  output logic    ready_o,
  output logic    load_o,
  output logic    slot_v_o,
  output wb_req_t slot_o
);

  logic accept;

  // Ready only looks at slot state and grant, so there is no path from valid_i.
  always_comb begin
    ready_o = !flush_i && (!slot_v_o || grant_i);
    accept  = valid_i && ready_o;
    load_o  = accept && (req_i.rd != REG_X0);
  end

  // Slot register: flush wins, then a new accept (x0 writes are swallowed), then drain on grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_v_o <= 1'b0;
      slot_o   <= '0;
    end else if (flush_i) begin
      slot_v_o <= 1'b0;
    end else if (accept) begin
      slot_v_o <= (req_i.rd != REG_X0);
      slot_o   <= req_i;
    end else if (grant_i) begin
      slot_v_o <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the ALU and LSU result slots
// and reports pending-write hazards on the decoder source indices.
module wb_port_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              regWrite_o,
  output logic [REG_AW-1:0] wrd_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard1_o,
  output logic              hazard2_o
);

  localparam int unsigned   CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic          alu_v, lsu_v, alu_load, lsu_load;
  logic          alu_gnt, lsu_gnt;
  wb_req_t       alu_q, lsu_q;
  logic          lsu_older;
  logic [CW-1:0] starve_cnt;

  wb_slot u_alu_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .valid_i  (alu_valid_i),
    .req_i    ('{rd: alu_rd_i, data: alu_data_i}),
    .grant_i  (alu_gnt),
    .ready_o  (alu_ready_o),
    .load_o   (alu_load),
    .slot_v_o (alu_v),
    .slot_o   (alu_q)
  );

  wb_slot u_lsu_slot (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .valid_i  (lsu_valid_i),
    .req_i    ('{rd: lsu_rd_i, data: lsu_data_i}),
    .grant_i  (lsu_gnt),
    .ready_o  (lsu_ready_o),
    .load_o   (lsu_load),
    .slot_v_o (lsu_v),
    .slot_o   (lsu_q)
  );

  // Priority: same-rd ordering, then ALU anti-starvation, then LSU, then ALU.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (alu_v && lsu_v && (alu_q.rd == lsu_q.rd)) begin
      if (lsu_older) lsu_gnt = 1'b1;
      else           alu_gnt = 1'b1;
    end else if (alu_v && (starve_cnt == STARVE_MAX)) begin
      alu_gnt = 1'b1;
    end else if (lsu_v) begin
      lsu_gnt = 1'b1;
    end else if (alu_v) begin
      alu_gnt = 1'b1;
    end
  end

  // Age bit: a slot that stays occupied across the other slot's load is the older one;
  // simultaneous loads treat the LSU as older.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lsu_older <= 1'b0;
    end else if (alu_load && (lsu_load || (lsu_v && !lsu_gnt))) begin
      lsu_older <= 1'b1;
    end else if (lsu_load && alu_v && !alu_gnt) begin
      lsu_older <= 1'b0;
    end
  end

  // Consecutive lost arbitration rounds for a waiting ALU result, saturating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (flush_i || !alu_v || alu_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Registered write port; index/data hold when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regWrite_o <= 1'b0;
      wrd_o      <= '0;
      wdata_o    <= '0;
    end else begin
      regWrite_o <= (alu_gnt || lsu_gnt) && !flush_i;
      if (!flush_i && alu_gnt) begin
        wrd_o   <= alu_q.rd;
        wdata_o <= alu_q.data;
      end else if (!flush_i && lsu_gnt) begin
        wrd_o   <= lsu_q.rd;
        wdata_o <= lsu_q.data;
      end
    end
  end

  // Pending-write hazard on either slot or the write currently on the port.
  always_comb begin
    hazard1_o = (rs1_i != REG_X0) &&
                (rd_match(alu_v, alu_q.rd, rs1_i) || rd_match(lsu_v, lsu_q.rd, rs1_i) ||
                 rd_match(regWrite_o, wrd_o, rs1_i));
    hazard2_o = (rs2_i != REG_X0) &&
                (rd_match(alu_v, alu_q.rd, rs2_i) || rd_match(lsu_v, lsu_q.rd, rs2_i) ||
                 rd_match(regWrite_o, wrd_o, rs2_i));
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued in arrival order
// and matched against each regWrite_o pulse; cycle-exact points are checked inline.
module tb_wb_port_arbiter;
  import rv_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              alu_valid_i = 1'b0, lsu_valid_i = 1'b0;
  logic              alu_ready_o, lsu_ready_o;
  logic [REG_AW-1:0] alu_rd_i = '0, lsu_rd_i = '0;
  logic [XLEN-1:0]   alu_data_i = '0, lsu_data_i = '0;
  logic              regWrite_o;
  logic [REG_AW-1:0] wrd_o;
  logic [XLEN-1:0]   wdata_o;
  logic [REG_AW-1:0] rs1_i = '0, rs2_i = '0;
  logic              hazard1_o, hazard2_o;

  int checks = 0;
  int failures = 0;
  wb_req_t exp_q[$];

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .regWrite_o(regWrite_o), .wrd_o(wrd_o), .wdata_o(wdata_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard1_o(hazard1_o), .hazard2_o(hazard2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_alu(input logic v, input logic [REG_AW-1:0] rd = '0,
                           input logic [XLEN-1:0] d = '0);
    alu_valid_i = v; alu_rd_i = rd; alu_data_i = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [REG_AW-1:0] rd = '0,
                           input logic [XLEN-1:0] d = '0);
    lsu_valid_i = v; lsu_rd_i = rd; lsu_data_i = d;
  endtask

  task automatic expect_wr(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_req_t e;
    e.rd = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk_i) begin
    if (rst_i && regWrite_o) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 32'(wrd_o) | 32'h100, 32'h0);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("sb_wrd", 32'(wrd_o), 32'(e.rd));
        check("sb_wdata", wdata_o, e.data);
      end
    end
  end

  initial begin
    // Reset state
    cyc(2);
    check("rst_we", regWrite_o, 1'b0);
    check("rst_wrd", 32'(wrd_o), 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_alu_rdy", alu_ready_o, 1'b1);
    check("rst_lsu_rdy", lsu_ready_o, 1'b1);
    rst_i = 1'b1;
    cyc();

    // Single ALU result: write appears two cycles later for one cycle
    drive_alu(1'b1, 5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    cyc();
    drive_alu(1'b0);
    rs1_i = 5'd5; rs2_i = 5'd6;
    #1;
    check("t2_c1_we", regWrite_o, 1'b0);
    check("t2_haz1_slot", hazard1_o, 1'b1);
    check("t2_haz2_none", hazard2_o, 1'b0);
    cyc();
    check("t2_c2_we", regWrite_o, 1'b1);
    check("t2_c2_wrd", 32'(wrd_o), 5);
    check("t2_c2_wdata", wdata_o, 32'h1234);
    check("t2_haz1_port", hazard1_o, 1'b1);
    cyc();
    check("t2_c3_we", regWrite_o, 1'b0);
    check("t2_haz1_clear", hazard1_o, 1'b0);
    rs1_i = '0; rs2_i = '0;

    // Conflict on distinct rd: LSU first, ALU next
    drive_alu(1'b1, 5'd3, 32'h333);
    drive_lsu(1'b1, 5'd7, 32'h777);
    expect_wr(5'd7, 32'h777);
    expect_wr(5'd3, 32'h333);
    cyc();
    drive_alu(1'b0); drive_lsu(1'b0);
    check("t3_alu_rdy_low", alu_ready_o, 1'b0);
    check("t3_lsu_rdy", lsu_ready_o, 1'b1);
    cyc();
    check("t3_alu_rdy_back", alu_ready_o, 1'b1);
    check("t3_first_wrd", 32'(wrd_o), 7);
    cyc();
    check("t3_second_we", regWrite_o, 1'b1);
    check("t3_second_wrd", 32'(wrd_o), 3);
    cyc();
    check("t3_idle_we", regWrite_o, 1'b0);

    // Starvation then same-rd ordering with LSU older
    drive_alu(1'b1, 5'd4, 32'h4444);
    drive_lsu(1'b1, 5'd16, 32'h1600);
    expect_wr(5'd16, 32'h1600);
    expect_wr(5'd17, 32'h1700);
    expect_wr(5'd18, 32'h1800);
    expect_wr(5'd19, 32'h1900);
    expect_wr(5'd4, 32'h4444);
    expect_wr(5'd9, 32'h9001);
    expect_wr(5'd9, 32'h9002);
    cyc();
    drive_alu(1'b0);
    for (int k = 1; k <= 4; k++) begin
      check("t5_alu_rdy_lost", alu_ready_o, 1'b0);
      if (k < 4) drive_lsu(1'b1, 5'(16 + k), 32'(32'h1600 + k * 32'h100));
      else       drive_lsu(1'b1, 5'd9, 32'h9001);
      cyc();
    end
    check("t5_alu_rdy_grant", alu_ready_o, 1'b1);
    check("t5_lsu_rdy_held", lsu_ready_o, 1'b0);
    drive_lsu(1'b0);
    drive_alu(1'b1, 5'd9, 32'h9002);
    cyc();
    drive_alu(1'b0);
    check("t5_forced_we", regWrite_o, 1'b1);
    check("t5_forced_wrd", 32'(wrd_o), 4);
    cyc();
    check("t4_lsu_first", wdata_o, 32'h9001);
    cyc();
    check("t4_alu_second", wdata_o, 32'h9002);
    cyc();

    // Same rd with ALU older: ALU written before LSU
    drive_alu(1'b1, 5'd9, 32'hB9A);
    drive_lsu(1'b1, 5'd20, 32'h2020);
    expect_wr(5'd20, 32'h2020);
    expect_wr(5'd9, 32'hB9A);
    expect_wr(5'd9, 32'hB9B);
    cyc();
    drive_alu(1'b0);
    drive_lsu(1'b1, 5'd9, 32'hB9B);
    cyc();
    drive_lsu(1'b0);
    cyc();
    check("t4b_alu_first", wdata_o, 32'hB9A);
    cyc(2);

    // x0 destination is dropped
    drive_alu(1'b1, 5'd0, 32'hDEAD);
    cyc();
    drive_alu(1'b0);
    check("t6_x0_rdy", alu_ready_o, 1'b1);
    cyc();
    check("t6_x0_we_c2", regWrite_o, 1'b0);
    cyc();
    check("t6_x0_we_c3", regWrite_o, 1'b0);

    // Flush with both slots full
    drive_alu(1'b1, 5'd12, 32'hC12);
    drive_lsu(1'b1, 5'd13, 32'hC13);
    cyc();
    drive_alu(1'b0); drive_lsu(1'b0);
    rs1_i = 5'd12;
    flush_i = 1'b1;
    #1;
    check("t6_flush_alu_rdy", alu_ready_o, 1'b0);
    check("t6_flush_lsu_rdy", lsu_ready_o, 1'b0);
    check("t6_flush_haz_pre", hazard1_o, 1'b1);
    cyc();
    flush_i = 1'b0;
    #1;
    check("t6_flush_we", regWrite_o, 1'b0);
    check("t6_flush_haz_post", hazard1_o, 1'b0);
    check("t6_flush_alu_rdy2", alu_ready_o, 1'b1);
    check("t6_flush_lsu_rdy2", lsu_ready_o, 1'b1);
    cyc();
    check("t6_flush_we2", regWrite_o, 1'b0);
    rs1_i = '0;

    // Asynchronous reset in the middle of a write
    drive_alu(1'b1, 5'd14, 32'hE14);
    drive_lsu(1'b1, 5'd15, 32'hF15);
    cyc();
    drive_alu(1'b0); drive_lsu(1'b0);
    cyc();
    check("t1_pre_rst_we", regWrite_o, 1'b1);
    check("t1_pre_rst_wrd", 32'(wrd_o), 15);
    rs1_i = 5'd14;
    rst_i = 1'b0;
    #1;
    check("t1_rst_we", regWrite_o, 1'b0);
    check("t1_rst_wrd", 32'(wrd_o), 0);
    check("t1_rst_wdata", wdata_o, 0);
    check("t1_rst_haz", hazard1_o, 1'b0);
    cyc();
    rst_i = 1'b1;
    rs1_i = '0;
    cyc();
    check("t1_post_alu_rdy", alu_ready_o, 1'b1);
    check("t1_post_lsu_rdy", lsu_ready_o, 1'b1);
    check("t1_post_we", regWrite_o, 1'b0);
    cyc(2);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
